// File: rtl/task_poll_scheduler_if.sv
// task_poll_scheduler_if
//   Bundles the task-control, configuration and resource-handshake signals of
//   task_poll_scheduler. Clock and reset are kept as plain ports on the block.
//
//   i_en          per-task enable mask
//   i_cfg_we      period write strobe
//   i_cfg_addr    task index for a period write
//   i_cfg_period  period in base ticks (0 disables the task)
//   i_done        resource finished the current job (one-cycle pulse)
//   o_start       one-cycle start pulse to the resource
//   o_sel         index of the granted task
//   o_busy        high while a job is outstanding
//   o_timeout     one-cycle pulse when a job is abandoned
//   o_overrun     sticky per-task overrun flags
//
//   master: the host / resource side; slave: the scheduler.
interface task_poll_scheduler_if #(
    parameter int unsigned C_N    = 4,
    parameter int unsigned C_BITS = 16
) ();
    logic [C_N-1:0]    i_en;
    logic              i_cfg_we;
    logic [2:0]        i_cfg_addr;
    logic [C_BITS-1:0] i_cfg_period;
    logic              i_done;
    logic              o_start;
    logic [2:0]        o_sel;
    logic              o_busy;
    logic              o_timeout;
    logic [C_N-1:0]    o_overrun;

    modport master (
        output i_en, i_cfg_we, i_cfg_addr, i_cfg_period, i_done,
        input  o_start, o_sel, o_busy, o_timeout, o_overrun
    );

    modport slave (
        input  i_en, i_cfg_we, i_cfg_addr, i_cfg_period, i_done,
        output o_start, o_sel, o_busy, o_timeout, o_overrun
    );
endinterface

// File: rtl/task_poll_scheduler.sv
// task_poll_scheduler
//   Shares one slow resource among C_N periodic tasks. A prescaler produces a
//   base tick every C_TICK_DIV cycles; each task counts its programmed period in
//   ticks and raises a pending request on expiry. A round-robin arbiter grants
//   one request at a time, pulses o_start and waits for i_done or for C_TMO
//   ticks before it grants again.
//
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   io_bus  task_poll_scheduler_if slave modport (enables, period config,
//           done in; start/sel/busy/timeout/overrun out)
module task_poll_scheduler #(
    parameter int unsigned C_N        = 4,
    parameter int unsigned C_BITS     = 16,
    parameter int unsigned C_TICK_DIV = 1000,
    parameter int unsigned C_TMO      = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    task_poll_scheduler_if.slave io_bus
);
    localparam int unsigned C_PW = $clog2(C_TICK_DIV);
    localparam int unsigned C_TW = (C_TMO > 255) ? $clog2(C_TMO + 1) : 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2
    } t_state;

    logic [C_PW-1:0]   r_presc;
    logic [C_BITS-1:0] r_period [C_N];
    logic [C_BITS-1:0] r_cnt    [C_N];
    logic [C_N-1:0]    r_pend;
    logic [C_N-1:0]    r_ovr;
    logic [2:0]        r_rr;
    logic [2:0]        r_sel;
    t_state            r_state;
    logic              r_start;
    logic              r_busy;
    logic              r_timeout;
    logic [C_TW-1:0]   r_tmo;

    logic              w_tick;
    logic              w_wr_ok;
    logic              w_found;
    logic              w_grant;
    logic [2:0]        w_win;
    logic [3:0]        w_dist;
    logic [3:0]        w_best;

    assign w_tick  = (r_presc == '0);
    assign w_wr_ok = io_bus.i_cfg_we && ({1'b0, io_bus.i_cfg_addr} < 4'(C_N));

    // Round-robin pick: pending task with the smallest distance past r_rr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = '1;
        w_dist  = '0;
        for (int k = 0; k < C_N; k++) begin
            w_dist = (3'(k) >= r_rr) ? (4'(k) - {1'b0, r_rr})
                                     : (4'(k) + 4'(C_N) - {1'b0, r_rr});
            if (r_pend[k] && (!w_found || (w_dist < w_best))) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_win   = 3'(k);
            end
        end
    end

    assign w_grant = (r_state == StIdle) && w_found;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_tick) begin
            r_presc <= C_PW'(C_TICK_DIV - 1);
        end else begin
            r_presc <= r_presc - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < C_N; k++) begin
                r_period[k] <= '0;
                r_cnt[k]    <= '0;
            end
            r_pend <= '0;
            r_ovr  <= '0;
        end else begin
            for (int k = 0; k < C_N; k++) begin
                if (w_wr_ok && (io_bus.i_cfg_addr == 3'(k))) begin
                    r_period[k] <= io_bus.i_cfg_period;
                    r_cnt[k]    <= io_bus.i_cfg_period - 1'b1;
                    r_pend[k]   <= 1'b0;
                    r_ovr[k]    <= 1'b0;
                end else if (!io_bus.i_en[k]) begin
                    r_pend[k] <= 1'b0;
                end else if ((r_period[k] != '0) && w_tick && (r_cnt[k] == '0)) begin
                    r_cnt[k]  <= r_period[k] - 1'b1;
                    r_pend[k] <= 1'b1;
                    // A grant in this same cycle services the old request.
                    if (r_pend[k] && !(w_grant && (w_win == 3'(k)))) begin
                        r_ovr[k] <= 1'b1;
                    end
                end else begin
                    if ((r_period[k] != '0) && w_tick) begin
                        r_cnt[k] <= r_cnt[k] - 1'b1;
                    end
                    if (w_grant && (w_win == 3'(k))) begin
                        r_pend[k] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_rr      <= '0;
            r_sel     <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_grant) begin
                        r_sel   <= w_win;
                        r_rr    <= (w_win == 3'(C_N - 1)) ? 3'd0 : (w_win + 3'd1);
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    r_tmo   <= C_TW'(C_TMO);
                    r_state <= StWait;
                end
                StWait: begin
                    // i_done wins over a timeout landing in the same cycle.
                    if (io_bus.i_done) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (w_tick) begin
                        r_tmo <= r_tmo - 1'b1;
                        if (r_tmo == C_TW'(1)) begin
                            r_timeout <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= StIdle;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign io_bus.o_start   = r_start;
    assign io_bus.o_sel     = r_sel;
    assign io_bus.o_busy    = r_busy;
    assign io_bus.o_timeout = r_timeout;
    assign io_bus.o_overrun = r_ovr;
endmodule

// File: doc/task_poll_scheduler.md
Name: task_poll_scheduler

Overview:
- Time-sliced scheduler that shares one slow peripheral (sensor bus / ADC / display update engine) among C_N periodic tasks.
- Each task has a programmable period in base ticks; an internal prescaler generates the base tick.
- When a task's period elapses it becomes pending. A round-robin arbiter issues a one-cycle start to the shared resource and waits for done or timeout before granting the next task.

Parameters:
- C_N, 4, number of tasks (2..8)
- C_BITS, 16, width of per-task period counters
- C_TICK_DIV, 1000, clock cycles per base tick (>=2)
- C_TMO, 255, timeout in base ticks while waiting for i_done (>=1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_en  in  C_N  per-task enable mask
- i_cfg_we  in  1  period write strobe
- i_cfg_addr  in  3  task index for write (only low log2(C_N) bits used)
- i_cfg_period  in  C_BITS  period in base ticks; 0 = task disabled
- i_done  in  1  resource finished current job (single-cycle pulse)
- o_start  out  1  one-cycle start pulse to resource
- o_sel  out  3  index of granted task, valid from o_start until completion
- o_busy  out  1  high from o_start cycle until job ends
- o_timeout  out  1  one-cycle pulse when a job is abandoned
- o_overrun  out  C_N  sticky: task expired while still pending

Behaviour:
- Reset: single clock, synchronous active-high reset. On reset:
  - All periods = 0; all counters = 0; pending = 0; o_overrun = 0.
  - Prescaler = C_TICK_DIV-1; RR pointer = 0; FSM = IDLE.
  - Outputs: o_start = 0, o_sel = 0, o_busy = 0, o_timeout = 0.
- Reset mid-job drops the job silently: no o_timeout, no completion.
- Prescaler:
  - Counts down every cycle from C_TICK_DIV-1. At 0 it asserts an internal tick for one cycle and reloads.
  - The first tick after reset occurs on cycle C_TICK_DIV.
- Config write (i_cfg_we=1):
  - Stores period[addr] and loads counter[addr] = period-1 in the same cycle.
  - Clears pending[addr] and o_overrun[addr].
  - An address >= C_N is ignored.
  - A write takes priority over a tick decrement of the same counter.
- Per-task counter (task active when period != 0 and i_en[k] = 1):
  - On tick, if counter == 0: reload period-1 and set pending[k]. If pending[k] was already 1, set o_overrun[k] (sticky).
  - Otherwise, decrement.
  - Inactive tasks hold their counter and cannot become pending. Deasserting i_en[k] also clears pending[k].
- Arbiter: round-robin starting at the RR pointer. The lowest index at or after the pointer with pending=1 wins, wrapping modulo C_N.
- FSM states and transitions:
  - IDLE: if any pending, latch winner into o_sel, clear pending[winner], set RR pointer = winner+1 mod C_N, go to START.
  - START: o_start=1 for exactly this cycle, o_busy=1; timeout counter = C_TMO; go to WAIT.
  - WAIT:
    - o_busy=1.
    - On i_done, go to IDLE.
    - Else, on tick, decrement the timeout counter. When it reaches 0, pulse o_timeout for one cycle and go to IDLE.
    - If i_done and timeout occur in the same cycle, i_done wins (no o_timeout).
- Timing and ignored inputs:
  - Decision latency: pending set on cycle t gives o_start on cycle t+2 if the FSM is IDLE at t+1.
  - i_done outside WAIT is ignored.
  - Back-to-back: a job ending in cycle t lets IDLE grant at t+1 and o_start at t+2.
  - Expiry of the currently-running task sets pending again (no overrun unless it was already pending).
- Width rules: counters are C_BITS wide. Period 1 means pending every tick. The timeout counter is 8 bits, or wider if C_TMO > 255.

Test Plan:
- C_TICK_DIV=4, task0 period=3, i_done returned 2 cycles after each o_start -> o_start with o_sel=0 every 12 clocks; o_overrun=0.
- Tasks 0,1,2 all period=1 and enabled, i_done 1 cycle after start -> grants cycle 0,1,2,0,1,2. Tasks expire faster than they are served, so o_overrun bits set (grant order preserved).
- Task1 period=2, i_done never asserted, C_TMO=3, C_TICK_DIV=4 -> o_timeout pulses 12 clocks after o_start (±prescaler phase ≤3); FSM returns to IDLE and grants again.
- i_done and timeout expiry forced in the same cycle -> no o_timeout; next grant proceeds normally.
- Config write of period=5 to task2 in the same cycle its counter would expire -> no pending; next pending exactly 5 ticks later; o_overrun[2] cleared.
- Assert i_rst during WAIT -> next cycle o_busy=0, o_timeout=0, pending=0; i_done arriving afterwards ignored; task i_en=0 with period=2 never pending.
